// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    PUSH,
    WAIT_IDLE
  } rx_state_t;

  // Parity mode encodings for the PARITY parameter.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Core clock cycles per serial bit (integer division).
  function automatic int bit_time(input int clock_freq, input int baud);
    return clock_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. A push that coincides with a pop
// is accepted even when full, because the pop frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic                     full_o,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer and occupancy; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array written on accepted pushes.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; an entry is only observable after it has been written.
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Configurable UART receiver: synchroniser, frame FSM with parity/framing/break
// detection, and a receive FIFO with sticky overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 1_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          data_out_perr,
  output logic                          data_out_ferr,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic                          overrun,
  output logic                          break_det,
  input  logic                          clear_errs,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_T  = bit_time(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_T = BIT_T / 2;
  localparam int CW     = $clog2(BIT_T) + 1;
  localparam int EW     = DATA_BITS + 2;

  // The PARITY parameter shadows the imported state name, so the state is
  // always referenced through the package scope.
  localparam rx_state_t ST_PARITY = uart_pkg::PARITY;

  rx_state_t            state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bits_q, bits_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 break_q, break_d;
  logic                 push, pop, sample;
  logic                 fifo_full, fifo_empty;
  logic [EW-1:0]        fifo_dout;

  assign rx_s   = sync_q[1];
  assign sample = (cnt_q == CW'(BIT_T - 1));
  assign pop    = data_out_valid && data_out_ready;

  // Two-flop synchroniser, preset to the idle line level.
  always_ff @(posedge clk) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], serial_in};
  end

  // Frame FSM: next state, bit timing, data shift and error accumulation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bits_d  = bits_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          bits_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (cnt_q == CW'(HALF_T - 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bits_d  = bits_q + 4'd1;
          if (bits_q == 4'(DATA_BITS - 1)) begin
            bits_d  = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : STOP;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rx_s) != (PARITY == PARITY_ODD);
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          cnt_d  = '0;
          bits_d = bits_q + 4'd1;
          if (!rx_s) ferr_d = 1'b1;
          if (bits_q == 4'(STOP_BITS - 1)) begin
            bits_d  = '0;
            state_d = PUSH;
          end
        end
      end
      PUSH: begin
        cnt_d   = '0;
        push    = 1'b1;
        state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Sticky overrun (a new set beats clear) and one-cycle break pulse.
  always_comb begin
    overrun_d = overrun_q;
    if (clear_errs)                      overrun_d = 1'b0;
    if (push && fifo_full && !pop)       overrun_d = 1'b1;
    break_d = push && (shift_q == '0) && ferr_q;
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
      break_q   <= break_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (push),
    .din_i   ({perr_q, ferr_q, shift_q}),
    .full_o  (fifo_full),
    .rd_en_i (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign data_out       = fifo_dout[DATA_BITS-1:0];
  assign data_out_ferr  = fifo_dout[DATA_BITS];
  assign data_out_perr  = fifo_dout[DATA_BITS+1];
  assign data_out_valid = !fifo_empty;
  assign overrun        = overrun_q;
  assign break_det      = break_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: instance A is 8N1 with an 8-deep FIFO, instance B is
// 7E2 with a 4-deep FIFO. Frames are built by a host model; expected entries
// go into per-instance queues that monitors pop on every handshake.
module tb_uart_rx_fifo;

  localparam int BIT_T   = 50;
  localparam int DEPTH_B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_a = 1'b1, serial_b = 1'b1;
  logic       ready_a = 1'b0, ready_b = 1'b0;
  logic       clear_a = 1'b0, clear_b = 1'b0;

  logic [7:0] dout_a;
  logic       perr_a, ferr_a, valid_a, ovr_a, brk_a;
  logic [3:0] cnt_a;
  logic [6:0] dout_b;
  logic       perr_b, ferr_b, valid_b, ovr_b, brk_b;
  logic [2:0] cnt_b;

  int         checks = 0;
  int         failures = 0;
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];
  int         brk_cnt_a = 0;
  int         brk_cnt_b = 0;
  bit         rand_ready_a = 1'b0;

  always #10 clk = ~clk;

  uart_rx_fifo #(
    .CLOCK_FREQ (50_000_000), .BAUD_RATE (1_000_000), .DATA_BITS (8),
    .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (8)
  ) dut_a (
    .clk (clk), .rst (rst), .serial_in (serial_a),
    .data_out (dout_a), .data_out_perr (perr_a), .data_out_ferr (ferr_a),
    .data_out_valid (valid_a), .data_out_ready (ready_a),
    .overrun (ovr_a), .break_det (brk_a), .clear_errs (clear_a),
    .fifo_count (cnt_a)
  );

  uart_rx_fifo #(
    .CLOCK_FREQ (50_000_000), .BAUD_RATE (1_000_000), .DATA_BITS (7),
    .PARITY (2), .STOP_BITS (2), .FIFO_DEPTH (DEPTH_B)
  ) dut_b (
    .clk (clk), .rst (rst), .serial_in (serial_b),
    .data_out (dout_b), .data_out_perr (perr_b), .data_out_ferr (ferr_b),
    .data_out_valid (valid_b), .data_out_ready (ready_b),
    .overrun (ovr_b), .break_det (brk_b), .clear_errs (clear_b),
    .fifo_count (cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int which, input logic v);
    if (which == 0) serial_a = v;
    else            serial_b = v;
    repeat (BIT_T) tick();
  endtask

  // Host model: build a frame for instance A (8N1) or B (7E2), queue the
  // expected FIFO entry {perr, ferr, data} unless B's FIFO is already full.
  task automatic send_char(input int which, input logic [8:0] data,
                           input bit flip_par, input logic [1:0] stop_vals);
    int         nb;
    logic [8:0] d;
    logic       par;
    logic       ferr_e;
    nb     = (which == 0) ? 8 : 7;
    d      = data & ((9'h1 << nb) - 9'h1);
    par    = (^d) ^ flip_par;
    ferr_e = !stop_vals[0] || (which == 1 && !stop_vals[1]);
    if (which == 0) q_a.push_back({1'b0, ferr_e, d});
    else if (q_b.size() < DEPTH_B) q_b.push_back({flip_par, ferr_e, d});
    drive_bit(which, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(which, d[i]);
    if (which == 1) drive_bit(which, par);
    drive_bit(which, stop_vals[0]);
    if (which == 1) drive_bit(which, stop_vals[1]);
    if (which == 0) serial_a = 1'b1;
    else            serial_b = 1'b1;
    repeat (100) tick();
  endtask

  task automatic wait_drain(input int which);
    int n;
    n = 0;
    while (((which == 0) ? q_a.size() : q_b.size()) != 0 && n < 1000) begin
      tick();
      n++;
    end
    check((which == 0) ? "a_drained" : "b_drained",
          32'((which == 0) ? q_a.size() : q_b.size()), 32'd0);
  endtask

  // Monitor A: compare each handshaken head entry with the oldest expected one.
  always @(negedge clk) begin
    logic [10:0] exp;
    if (rst && valid_a && ready_a) begin
      check("a_pending", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        exp = q_a.pop_front();
        check("a_entry", 32'({perr_a, ferr_a, 1'b0, dout_a}), 32'(exp));
      end
    end
    if (brk_a) brk_cnt_a++;
  end

  // Monitor B.
  always @(negedge clk) begin
    logic [10:0] exp;
    if (rst && valid_b && ready_b) begin
      check("b_pending", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        exp = q_b.pop_front();
        check("b_entry", 32'({perr_b, ferr_b, 2'b0, dout_b}), 32'(exp));
      end
    end
    if (brk_b) brk_cnt_b++;
  end

  // Random back-pressure on A while enabled.
  always @(posedge clk) begin
    if (rand_ready_a) begin
      #1;
      ready_a = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_count_a", 32'(cnt_a), 32'd0);
    check("rst_ovr_a", 32'(ovr_a), 32'd0);
    check("rst_brk_a", 32'(brk_a), 32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    check("rst_count_b", 32'(cnt_b), 32'd0);
    rst = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    repeat (20) tick();

    // 8N1 ordered characters.
    for (int c = 'h61; c <= 'h6A; c++) send_char(0, 9'(c), 1'b0, 2'b11);
    wait_drain(0);
    check("a_no_overrun", 32'(ovr_a), 32'd0);

    // Random characters under random back-pressure.
    rand_ready_a = 1'b1;
    for (int i = 0; i < 8; i++) send_char(0, 9'($urandom_range(0, 255)), 1'b0, 2'b11);
    rand_ready_a = 1'b0;
    tick();
    tick();
    ready_a = 1'b1;
    wait_drain(0);

    // Framing error on a non-zero character: no break.
    send_char(0, 9'h0A5, 1'b0, 2'b00);
    wait_drain(0);
    check("a_no_break_yet", 32'(brk_cnt_a), 32'd0);

    // Break: line low 12 bit times gives one {0, ferr} entry and one pulse.
    q_a.push_back({1'b0, 1'b1, 9'h000});
    serial_a = 1'b0;
    repeat (12 * BIT_T) tick();
    serial_a = 1'b1;
    repeat (100) tick();
    send_char(0, 9'h042, 1'b0, 2'b11);
    wait_drain(0);
    check("a_break_pulses", 32'(brk_cnt_a), 32'd1);

    // Start-bit glitch produces no entry.
    ready_a = 1'b0;
    serial_a = 1'b0;
    repeat (20) tick();
    serial_a = 1'b1;
    repeat (200) tick();
    check("a_glitch_count", 32'(cnt_a), 32'd0);

    // One buffered entry, then reset during the DATA phase of the next frame.
    send_char(0, 9'h011, 1'b0, 2'b11);
    check("a_buffered", 32'(cnt_a), 32'd1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rst = 1'b0;
    serial_a = 1'b1;
    tick();
    check("a_midrst_count", 32'(cnt_a), 32'd0);
    check("a_midrst_valid", 32'(valid_a), 32'd0);
    q_a.delete();
    q_b.delete();
    rst = 1'b1;
    repeat (100) tick();
    ready_a = 1'b1;
    send_char(0, 9'h07E, 1'b0, 2'b11);
    wait_drain(0);

    // 7E2: parity good / bad, second stop bit bad, then a clean frame.
    send_char(1, 9'h055, 1'b0, 2'b11);
    send_char(1, 9'h055, 1'b1, 2'b11);
    send_char(1, 9'h0A5, 1'b0, 2'b01);
    send_char(1, 9'h03C, 1'b0, 2'b11);
    wait_drain(1);

    // Fill the 4-deep FIFO, then overflow it.
    ready_b = 1'b0;
    for (int i = 0; i < DEPTH_B; i++) send_char(1, 9'($urandom_range(1, 127)), 1'b0, 2'b11);
    check("b_full_count", 32'(cnt_b), 32'(DEPTH_B));
    check("b_full_no_ovr", 32'(ovr_b), 32'd0);
    send_char(1, 9'($urandom_range(1, 127)), 1'b0, 2'b11);
    check("b_ovr_count", 32'(cnt_b), 32'(DEPTH_B));
    check("b_ovr_set", 32'(ovr_b), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("b_head_held", 32'({perr_b, ferr_b, 2'b0, dout_b}), 32'(q_b[0]));
      tick();
    end
    clear_b = 1'b1;
    tick();
    clear_b = 1'b0;
    check("b_ovr_cleared", 32'(ovr_b), 32'd0);
    ready_b = 1'b1;
    wait_drain(1);

    check("b_no_break", 32'(brk_cnt_b), 32'd0);
    check("a_final_ovr", 32'(ovr_a), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
